icache_axi_rd: RTL and testbench

Parametrised AXI4-style read-burst instruction memory. It is the next-generation ICache behind the Core fetch port. It generalises the fixed single-mode ICache in four ways: configurable data width and depth, FIXED/INCR/WRAP bursts, per-beat RRESP error reporting, and a side-band preload write port. It sits between the Core fetch unit and the instruction storage in Top.

---
 rtl/icache_axi_rd_if.sv | 30 +++
 rtl/icache_axi_rd.sv | 205 ++++++++++++++++++++
 tb/tb_icache_axi_rd.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_axi_rd_if.sv
// AXI4-style read channel bundle (AR + R) between the fetch unit and icache_axi_rd.
// A transfer happens on a channel only in a cycle where both valid and ready are high; the
// source holds valid and all payload steady until it is accepted, and ready may toggle freely.
interface icache_axi_rd_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [1:0]        arburst;
  logic [2:0]        arsize;
  logic [LEN_W-1:0]  arlen;
  logic              arready;
  logic              rready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport slave (
    input  arvalid, araddr, arburst, arsize, arlen, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

  modport master (
    output arvalid, araddr, arburst, arsize, arlen, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/icache_axi_rd.sv
// Burst-read instruction memory with FIXED/INCR/WRAP bursts, SLVERR reporting and a preload port.
// Optional macro ICACHE_B2B_EN: accept the next AR while the final beat is presented (no idle gap).
module icache_axi_rd #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  icache_axi_rd_if.slave           bus,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     dbg_state_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF   = $clog2(DATA_W / 8);

  localparam logic [1:0] B_INCR      = 2'b01;
  localparam logic [1:0] B_WRAP      = 2'b10;
  localparam logic [1:0] B_RSVD      = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        burst_q;
  logic [2:0]        size_q;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic              err_q;
  logic              rvalid_q, rlast_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              arready, ar_hs, xfer, last_xfer, start, load_beat;
  logic [ADDR_W-1:0] s_addr;
  logic [1:0]        s_burst;
  logic [2:0]        s_size;
  logic [LEN_W-1:0]  s_len;
  logic [ADDR_W-1:0] beat_addr, beat_idx;
  logic              beat_err, beat_oob;

`ifdef ICACHE_B2B_EN
  logic              pend_q, capture;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [1:0]        pend_burst_q;
  logic [2:0]        pend_size_q;
  logic [LEN_W-1:0]  pend_len_q;
`endif

  function automatic logic req_bad(input logic [ADDR_W-1:0] a, input logic [1:0] b,
                                   input logic [2:0] s, input logic [LEN_W-1:0] l);
    logic [ADDR_W-1:0] step;
    logic              bad;
    step = ADDR_W'(1) << s;
    bad  = (b == B_RSVD) || (s > 3'(OFF));
    if (b == B_WRAP) begin
      if (!(l == LEN_W'(1) || l == LEN_W'(3) || l == LEN_W'(7) || l == LEN_W'(15))) bad = 1'b1;
      if ((a & (step - ADDR_W'(1))) != '0) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [1:0] b,
                                                  input logic [2:0] s, input logic [LEN_W-1:0] l);
    logic [ADDR_W-1:0] step, mask, res;
    step = ADDR_W'(1) << s;
    mask = (step * (ADDR_W'(l) + ADDR_W'(1))) - ADDR_W'(1);
    case (b)
      B_INCR:  res = a + step;
      B_WRAP:  res = (a & ~mask) | ((a + step) & mask);
      default: res = a;
    endcase
    return res;
  endfunction

  always_comb begin
    // run_q keeps arready low while in reset and for the first cycle after release
    arready = run_q && (state_q == IDLE);
`ifdef ICACHE_B2B_EN
    if (state_q == BURST) arready = rvalid_q && rlast_q && !pend_q;
    capture = 1'b0;
`endif
    ar_hs     = bus.arvalid && arready;
    xfer      = rvalid_q && bus.rready;
    last_xfer = xfer && rlast_q;
    s_addr    = bus.araddr;
    s_burst   = bus.arburst;
    s_size    = bus.arsize;
    s_len     = bus.arlen;
    start     = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          start   = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (last_xfer) state_d = IDLE;
`ifdef ICACHE_B2B_EN
        if (last_xfer && pend_q) begin
          start   = 1'b1;
          s_addr  = pend_addr_q;
          s_burst = pend_burst_q;
          s_size  = pend_size_q;
          s_len   = pend_len_q;
          state_d = BURST;
        end else if (last_xfer && ar_hs) begin
          start   = 1'b1;
          state_d = BURST;
        end else if (ar_hs) begin
          capture = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    load_beat = start || (xfer && !rlast_q);
    beat_addr = start ? s_addr : next_addr(addr_q, burst_q, size_q, len_q);
    beat_err  = start ? req_bad(s_addr, s_burst, s_size, s_len) : err_q;
    beat_idx  = beat_addr >> OFF;
    beat_oob  = beat_idx >= ADDR_W'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < (IDX_W + 1)'(DEPTH))) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      addr_q   <= '0;
      burst_q  <= '0;
      size_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (load_beat) begin
        // Registered read: old word is returned when a preload hits the same index this edge
        addr_q   <= beat_addr;
        rvalid_q <= 1'b1;
        rresp_q  <= (beat_err || beat_oob) ? RESP_SLVERR : RESP_OKAY;
        rdata_q  <= (beat_err || beat_oob) ? '0 : mem[beat_idx[IDX_W-1:0]];
        if (start) begin
          burst_q <= s_burst;
          size_q  <= s_size;
          len_q   <= s_len;
          err_q   <= beat_err;
          cnt_q   <= '0;
          rlast_q <= (s_len == '0);
        end else begin
          cnt_q   <= cnt_q + LEN_W'(1);
          rlast_q <= ((cnt_q + LEN_W'(1)) == len_q);
        end
      end else if (last_xfer) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
        rresp_q  <= RESP_OKAY;
        rdata_q  <= '0;
      end
    end
  end

`ifdef ICACHE_B2B_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_burst_q <= '0;
      pend_size_q  <= '0;
      pend_len_q   <= '0;
    end else if (capture) begin
      pend_q       <= 1'b1;
      pend_addr_q  <= bus.araddr;
      pend_burst_q <= bus.arburst;
      pend_size_q  <= bus.arsize;
      pend_len_q   <= bus.arlen;
    end else if (start) begin
      pend_q <= 1'b0;
    end
  end
`endif

  assign bus.arready  = arready;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.rresp    = rresp_q;
  assign bus.rlast    = rlast_q;
  assign dbg_state_o  = (state_q == BURST);
endmodule

// File: tb/tb_icache_axi_rd.sv
// Bench for icache_axi_rd: vector table, hand-written corner sequences and random bursts
// checked against an address-arithmetic reference model of the burst rules.
`timescale 1ns/1ps
module tb_icache_axi_rd;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        dbg_state;

  always #5 clk = ~clk;

  icache_axi_rd_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

  icache_axi_rd #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [34:0] exp_q[$];   // {rdata, rresp, rlast} per expected beat

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [2:0]  size;
    int          len;
    int          mode;       // 0: rready high, 1: 1,0,0,1 pattern, 2: random
    logic [31:0] exp_first;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: beat list from the burst rules using plain arithmetic
  task automatic build_exp(input logic [31:0] addr, input logic [1:0] burst,
                           input logic [2:0] size, input int len);
    longint step, a, idx, cont, base;
    bit     bad_req;
    step = longint'(1) << size;
    a    = longint'(addr);
    bad_req = (burst == 2'd3) || (step > 4) ||
              (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
              (burst == 2'd2 && (a % step) != 0);
    exp_q.delete();
    for (int i = 0; i <= len; i++) begin
      idx = a / 4;
      if (bad_req || idx >= DEPTH) exp_q.push_back({32'h0, 2'b10, 1'(i == len)});
      else exp_q.push_back({ref_mem[idx], 2'b00, 1'(i == len)});
      if (burst == 2'd1) a = (a + step) % (longint'(1) << 32);
      else if (burst == 2'd2) begin
        cont = step * (len + 1);
        base = a - (a % cont);
        a    = base + ((a - base + step) % cont);
      end
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 10'(idx); wr_data = data;
    ref_mem[idx] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_burst(input string tag, input logic [31:0] addr, input logic [1:0] burst,
                           input logic [2:0] size, input int len, input int mode,
                           output logic [31:0] first_data, output logic [1:0] first_resp,
                           output int nbeats);
    int cyc, k;
    bit done;
    logic [34:0] e;
    first_data = '0; first_resp = '0; nbeats = 0;
    build_exp(addr, burst, size, len);
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arburst = burst;
    bus.arsize = size; bus.arlen = LEN_W'(len); bus.rready = 1'b0;
    cyc = 0;
    while (!bus.arready && cyc < 20) begin @(negedge clk); cyc++; end
    if (!bus.arready) begin
      check({tag, "_ar_timeout"}, 64'(bus.arready), 64'd1);
      bus.arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check({tag, "_first_latency"}, 64'(bus.rvalid), 64'd1);
    done = 0; cyc = 0; k = 0;
    while (!done && cyc < 400) begin
      case (mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = ((k % 4) == 0) || ((k % 4) == 3);
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      k++;
      if (mode == 0) check({tag, "_gap"}, 64'(bus.rvalid), 64'd1);
      if (bus.rvalid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_overrun"}, 64'(nbeats), 64'(len + 1));
          done = 1;
        end else begin
          e = exp_q[0];
          check({tag, "_rdata"}, 64'(bus.rdata), 64'(e[34:3]));
          check({tag, "_rresp"}, 64'(bus.rresp), 64'(e[2:1]));
          check({tag, "_rlast"}, 64'(bus.rlast), 64'(e[0]));
          if (bus.rready) begin
            void'(exp_q.pop_front());
            nbeats++;
            if (nbeats == 1) begin first_data = bus.rdata; first_resp = bus.rresp; end
            if (bus.rlast) done = 1;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.rready = 1'b0;
    if (!done) check({tag, "_beat_timeout"}, 64'(done), 64'd1);
    check({tag, "_beats"}, 64'(nbeats), 64'(len + 1));
    check({tag, "_idle_after"}, 64'(bus.rvalid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fd, old5;
    logic [1:0]  fr;
    int          nb, run, maxrun, beats;
    bit          got2, clr;
    logic [1:0]  rb;
    logic [2:0]  rs;
    int          rl;
    logic [31:0] ra;

    wr_en = 0; wr_addr = '0; wr_data = '0;
    bus.arvalid = 0; bus.araddr = '0; bus.arburst = '0; bus.arsize = '0;
    bus.arlen = '0; bus.rready = 0;

    repeat (3) @(negedge clk);
    check("rst_arready", 64'(bus.arready), 64'd0);
    check("rst_rvalid",  64'(bus.rvalid),  64'd0);
    check("rst_rlast",   64'(bus.rlast),   64'd0);
    check("rst_rresp",   64'(bus.rresp),   64'd0);
    check("rst_rdata",   64'(bus.rdata),   64'd0);
    check("rst_state",   64'(dbg_state),   64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_arready", 64'(bus.arready), 64'd1);

    for (int i = 0; i < 8; i++) preload(i, 32'h100 + i);
    for (int i = 8; i < 128; i++) preload(i, $urandom);
    for (int i = 1016; i < 1024; i++) preload(i, $urandom);
    preload(1022, 32'hCAFE03FE);
    preload(1023, 32'hCAFE03FF);

    vecs[0]  = '{32'h0,        2'd1, 3'd2, 3, 0, 32'h100,      2'b00};
    vecs[1]  = '{32'h8,        2'd2, 3'd2, 3, 0, 32'h102,      2'b00};
    vecs[2]  = '{32'h0,        2'd1, 3'd2, 3, 1, 32'h100,      2'b00};
    vecs[3]  = '{32'hFF8,      2'd1, 3'd2, 3, 0, 32'hCAFE03FE, 2'b00};
    vecs[4]  = '{32'h0,        2'd3, 3'd2, 1, 0, 32'h0,        2'b10};
    vecs[5]  = '{32'h0,        2'd1, 3'd3, 1, 0, 32'h0,        2'b10};
    vecs[6]  = '{32'h4,        2'd2, 3'd2, 2, 0, 32'h0,        2'b10};
    vecs[7]  = '{32'h6,        2'd2, 3'd2, 3, 0, 32'h0,        2'b10};
    vecs[8]  = '{32'h10,       2'd0, 3'd2, 2, 2, 32'h104,      2'b00};
    vecs[9]  = '{32'hFFFFFFF8, 2'd1, 3'd2, 3, 0, 32'h0,        2'b10};
    vecs[10] = '{32'h5,        2'd1, 3'd0, 4, 2, 32'h101,      2'b00};
    vecs[11] = '{32'h1C,       2'd1, 3'd2, 0, 0, 32'h107,      2'b00};
    vecs[12] = '{32'hE,        2'd2, 3'd1, 7, 2, 32'h103,      2'b00};

    for (int v = 0; v < 13; v++) begin
      run_burst($sformatf("vec%0d", v), vecs[v].addr, vecs[v].burst, vecs[v].size,
                vecs[v].len, vecs[v].mode, fd, fr, nb);
      check($sformatf("vec%0d_first_data", v), 64'(fd), 64'(vecs[v].exp_first));
      check($sformatf("vec%0d_first_resp", v), 64'(fr), 64'(vecs[v].exp_resp));
    end

    // Preload hitting the word being read in the same edge returns the old data
    old5 = ref_mem[5];
    @(negedge clk);
    check("wr_rd_arready", 64'(bus.arready), 64'd1);
    bus.arvalid = 1; bus.araddr = 32'h14; bus.arburst = 2'd0; bus.arsize = 3'd2; bus.arlen = 8'd1;
    wr_en = 1; wr_addr = 10'd5; wr_data = 32'h5555AAAA;
    @(negedge clk);
    bus.arvalid = 0; wr_en = 0;
    check("wr_rd_old_valid", 64'(bus.rvalid), 64'd1);
    check("wr_rd_old_data",  64'(bus.rdata),  64'(old5));
    bus.rready = 1;
    @(negedge clk);
    check("wr_rd_new_data", 64'(bus.rdata), 64'h5555AAAA);
    check("wr_rd_new_last", 64'(bus.rlast), 64'd1);
    ref_mem[5] = 32'h5555AAAA;
    @(negedge clk);
    bus.rready = 0;
    check("wr_rd_done", 64'(bus.rvalid), 64'd0);

    for (int n = 0; n < 40; n++) begin
      rb = 2'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 3));
      rl = $urandom_range(0, 15);
      ra = ($urandom_range(0, 4) == 0) ? 32'hFF0 + $urandom_range(0, 15) : $urandom_range(0, 255);
      if (rb == 2'd2 && $urandom_range(0, 3) != 0) begin
        rs = 3'($urandom_range(0, 2));
        case ($urandom_range(0, 3)) 0: rl = 1; 1: rl = 3; 2: rl = 7; default: rl = 15; endcase
        ra = ra & ~((32'd1 << rs) - 1);
      end
      run_burst($sformatf("rnd%0d", n), ra, rb, rs, rl, 2, fd, fr, nb);
    end

    // Final beat stalled: arready behaviour and start of the following burst
    @(negedge clk);
    bus.arvalid = 1; bus.araddr = 32'h0; bus.arburst = 2'd1; bus.arsize = 3'd2; bus.arlen = 8'd0;
    @(negedge clk);
    bus.araddr = 32'h4;
    check("stall_last_rlast", 64'(bus.rlast), 64'd1);
`ifdef ICACHE_B2B_EN
    check("stall_last_arready", 64'(bus.arready), 64'd1);
    @(negedge clk);
    bus.arvalid = 0;
    check("held_arready", 64'(bus.arready), 64'd0);
    check("held_rdata", 64'(bus.rdata), 64'(ref_mem[0]));
    bus.rready = 1;
    @(negedge clk);
    check("held_next_valid", 64'(bus.rvalid), 64'd1);
    check("held_next_data", 64'(bus.rdata), 64'(ref_mem[1]));
    @(negedge clk);
    check("held_next_done", 64'(bus.rvalid), 64'd0);
`else
    check("stall_last_arready", 64'(bus.arready), 64'd0);
    bus.arvalid = 0;
    bus.rready = 1;
    @(negedge clk);
    check("gap_rvalid", 64'(bus.rvalid), 64'd0);
    check("gap_arready", 64'(bus.arready), 64'd1);
`endif
    bus.rready = 0;

    // Reset asserted while beat 2 of an 8-beat burst is presented
    @(negedge clk);
    bus.arvalid = 1; bus.araddr = 32'h0; bus.arburst = 2'd1; bus.arsize = 3'd2; bus.arlen = 8'd7;
    bus.rready = 1;
    @(negedge clk);
    bus.arvalid = 0;
    repeat (2) @(negedge clk);
    check("mid_rst_beat2", 64'(bus.rdata), 64'(ref_mem[2]));
    #2 rst_n = 0;
    #1;
    check("mid_rst_rvalid",  64'(bus.rvalid),  64'd0);
    check("mid_rst_rlast",   64'(bus.rlast),   64'd0);
    check("mid_rst_rdata",   64'(bus.rdata),   64'd0);
    check("mid_rst_arready", 64'(bus.arready), 64'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("after_rst_arready", 64'(bus.arready), 64'd1);
    for (int c = 0; c < 5; c++) begin
      check("after_rst_no_rvalid", 64'(bus.rvalid), 64'd0);
      @(negedge clk);
    end
    bus.rready = 0;

`ifdef ICACHE_B2B_EN
    // Two INCR bursts offered back to back stream without a bubble
    @(negedge clk);
    bus.arvalid = 1; bus.araddr = 32'h0; bus.arburst = 2'd1; bus.arsize = 3'd2; bus.arlen = 8'd3;
    bus.rready = 1;
    @(negedge clk);
    bus.araddr = 32'h10;
    run = 0; maxrun = 0; beats = 0; got2 = 0; clr = 0;
    for (int c = 0; c < 16; c++) begin
      if (bus.rvalid) begin
        run++;
        if (beats < 8) check("b2b_rdata", 64'(bus.rdata), 64'(ref_mem[beats]));
        beats++;
      end else run = 0;
      if (run > maxrun) maxrun = run;
      if (!got2 && bus.arready) begin got2 = 1; clr = 1; end
      @(negedge clk);
      if (clr) begin bus.arvalid = 0; clr = 0; end
    end
    bus.arvalid = 0; bus.rready = 0;
    check("b2b_contiguous", 64'(maxrun), 64'd8);
    check("b2b_beats", 64'(beats), 64'd8);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
